// File: rtl/floo_sa_global_ctrl.sv
// floo_sa_global_ctrl: per-output-port global switch allocation for the VC router.
// Picks one input among the local-SA winners targeting this output, tracks
// downstream credits per VC, and holds the output for a multi-flit packet
// (wormhole lock) until its tail has traversed.
// Optional build macro FLOO_SA_CREDIT_BYPASS_EN: a credit returned in the same
// cycle makes its VC eligible even when the counter is 0.
module floo_sa_global_ctrl #(
  parameter int NumInputs  = 5,
  parameter int NumVC      = 4,
  parameter int NumVCWidth = NumVC > 1 ? $clog2(NumVC) : 1,
  parameter int VCDepth    = 2,
  parameter int CntWidth   = $clog2(VCDepth + 1),
  parameter int IdWidth    = NumInputs > 1 ? $clog2(NumInputs) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumInputs-1:0]                  req_v_i,
  input  logic [NumInputs-1:0][NumVCWidth-1:0]  req_vc_i,
  input  logic [NumInputs-1:0]                  req_last_i,
  input  logic                                  credit_v_i,
  input  logic [NumVCWidth-1:0]                 credit_id_i,
  output logic [NumInputs-1:0]                  gnt_oh_o,
  output logic                                  gnt_v_o,
  output logic [IdWidth-1:0]                    gnt_id_o,
  output logic [NumVCWidth-1:0]                 gnt_vc_o,
  output logic [NumInputs-1:0]                  update_rr_arb_o,
  output logic                                  locked_o,
  output logic [NumVC-1:0][CntWidth-1:0]        credit_cnt_o,
  output logic                                  credit_err_o
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(VCDepth);

  lock_state_e                   state_q, state_d;
  logic [IdWidth-1:0]            lock_id_q, lock_id_d;
  logic [NumVCWidth-1:0]         lock_vc_q, lock_vc_d;
  logic [IdWidth-1:0]            ptr_q, ptr_d;
  logic [NumVC-1:0][CntWidth-1:0] cnt_q, cnt_d;
  logic                          err_q, err_d;

  logic [NumInputs-1:0]          eligible;
  logic [NumInputs-1:0]          candidate;
  logic                          gnt_found;
  logic [IdWidth-1:0]            gnt_idx;
  logic                          gnt_v;
  logic [NumVCWidth-1:0]         gnt_vc;
  logic [NumVC-1:0]              credit_inc, credit_dec;

  // Eligibility per input and the lock mask that restricts candidates.
  // NOTE: every variable written in a combinational block gets a default
  // first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    eligible  = '0;
    candidate = '0;
    for (int i = 0; i < NumInputs; i++) begin
`ifdef FLOO_SA_CREDIT_BYPASS_EN
      eligible[i] = req_v_i[i] &&
                    ((cnt_q[req_vc_i[i]] != '0) ||
                     (credit_v_i && (credit_id_i == req_vc_i[i])));
`else
      eligible[i] = req_v_i[i] && (cnt_q[req_vc_i[i]] != '0);
`endif
    end
    if (state_q == LOCKED) begin
      candidate[lock_id_q] = eligible[lock_id_q];
    end else begin
      candidate = eligible;
    end
  end

  // Round-robin search starting at the pointer; when locked only lock_id
  // can be a candidate, so the same search yields it.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NumInputs; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NumInputs) idx = idx - NumInputs;
      if (!gnt_found && candidate[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdWidth'(idx);
      end
    end
  end

  // No flit traverses while reset is asserted, even if requests are held.
  assign gnt_v           = gnt_found && rst_ni;
  assign gnt_vc          = gnt_v ? req_vc_i[gnt_idx] : '0;
  assign gnt_v_o         = gnt_v;
  assign gnt_id_o        = gnt_v ? gnt_idx : '0;
  assign gnt_vc_o        = gnt_vc;
  assign gnt_oh_o        = gnt_v ? (NumInputs'(1) << gnt_idx) : '0;
  assign update_rr_arb_o = gnt_oh_o;
  assign locked_o        = (state_q == LOCKED);
  assign credit_cnt_o    = cnt_q;
  assign credit_err_o    = err_q;

  // Lock FSM next state, lock capture and round-robin pointer update.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    lock_vc_d = lock_vc_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      UNLOCKED: begin
        if (gnt_v) begin
          ptr_d = (int'(gnt_idx) == NumInputs - 1) ? '0 : gnt_idx + IdWidth'(1);
          if (!req_last_i[gnt_idx]) begin
            state_d   = LOCKED;
            lock_id_d = gnt_idx;
            lock_vc_d = gnt_vc;
          end
        end
      end
      LOCKED: begin
        // Pointer frozen while a packet holds the output.
        if (gnt_v && req_last_i[gnt_idx]) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Credit counters: a grant consumes, a returned credit refills; both on the
  // same VC cancel. Overflowing returns saturate and raise the sticky error.
  always_comb begin
    cnt_d      = cnt_q;
    err_d      = err_q;
    credit_inc = '0;
    credit_dec = '0;
    for (int v = 0; v < NumVC; v++) begin
      credit_inc[v] = credit_v_i && (credit_id_i == NumVCWidth'(v));
      credit_dec[v] = gnt_v && (gnt_vc == NumVCWidth'(v));
      if (credit_inc[v] && !credit_dec[v]) begin
        if (cnt_q[v] == FullCnt) err_d = 1'b1;
        else cnt_d[v] = cnt_q[v] + CntWidth'(1);
      end else if (credit_dec[v] && !credit_inc[v] && (cnt_q[v] != '0)) begin
        cnt_d[v] = cnt_q[v] - CntWidth'(1);
      end
    end
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= UNLOCKED;
      lock_id_q <= '0;
      lock_vc_q <= '0;
      ptr_q     <= '0;
      cnt_q     <= {NumVC{FullCnt}};
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      lock_vc_q <= lock_vc_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // The locked input must keep requesting the VC its packet was granted on.
  lock_vc_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCKED && req_v_i[lock_id_q]) |-> (req_vc_i[lock_id_q] == lock_vc_q));

endmodule

// File: tb/tb_floo_sa_global_ctrl.sv
// Self-checking bench for floo_sa_global_ctrl: directed scenarios plus
// randomized packet traffic compared against a behavioural model.
module tb_floo_sa_global_ctrl;

  localparam int NumInputs  = 5;
  localparam int NumVC      = 4;
  localparam int NumVCWidth = 2;
  localparam int VCDepth    = 2;
  localparam int CntWidth   = 2;
  localparam int IdWidth    = 3;

  logic                                 clk_i = 1'b0;
  logic                                 rst_ni;
  logic [NumInputs-1:0]                 req_v_i;
  logic [NumInputs-1:0][NumVCWidth-1:0] req_vc_i;
  logic [NumInputs-1:0]                 req_last_i;
  logic                                 credit_v_i;
  logic [NumVCWidth-1:0]                credit_id_i;
  logic [NumInputs-1:0]                 gnt_oh_o;
  logic                                 gnt_v_o;
  logic [IdWidth-1:0]                   gnt_id_o;
  logic [NumVCWidth-1:0]                gnt_vc_o;
  logic [NumInputs-1:0]                 update_rr_arb_o;
  logic                                 locked_o;
  logic [NumVC-1:0][CntWidth-1:0]       credit_cnt_o;
  logic                                 credit_err_o;

  int checks = 0;
  int failures = 0;

  // Behavioural model state.
  int m_cnt[NumVC];
  bit m_locked;
  int m_lock_id;
  int m_ptr;
  bit m_err;
  bit e_v;
  int e_id;
  int e_vc;

  // Random traffic sources: one packet in flight per input.
  int src_vc[NumInputs];
  int src_left[NumInputs];

  floo_sa_global_ctrl #(
    .NumInputs (NumInputs),
    .NumVC     (NumVC),
    .VCDepth   (VCDepth)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_v_i         (req_v_i),
    .req_vc_i        (req_vc_i),
    .req_last_i      (req_last_i),
    .credit_v_i      (credit_v_i),
    .credit_id_i     (credit_id_i),
    .gnt_oh_o        (gnt_oh_o),
    .gnt_v_o         (gnt_v_o),
    .gnt_id_o        (gnt_id_o),
    .gnt_vc_o        (gnt_vc_o),
    .update_rr_arb_o (update_rr_arb_o),
    .locked_o        (locked_o),
    .credit_cnt_o    (credit_cnt_o),
    .credit_err_o    (credit_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NumVC; v++) m_cnt[v] = VCDepth;
    m_locked  = 1'b0;
    m_lock_id = 0;
    m_ptr     = 0;
    m_err     = 1'b0;
  endtask

  // Expected grant from the current inputs and model state.
  task automatic model_eval();
    bit elig[NumInputs];
    e_v = 1'b0; e_id = 0; e_vc = 0;
    for (int i = 0; i < NumInputs; i++) begin
      int vc = int'(req_vc_i[i]);
      bool_fill: begin
`ifdef FLOO_SA_CREDIT_BYPASS_EN
        elig[i] = req_v_i[i] && (m_cnt[vc] > 0 || (credit_v_i && int'(credit_id_i) == vc));
`else
        elig[i] = req_v_i[i] && (m_cnt[vc] > 0);
`endif
      end
    end
    if (m_locked) begin
      if (elig[m_lock_id]) begin e_v = 1'b1; e_id = m_lock_id; end
    end else begin
      for (int d = 0; d < NumInputs; d++) begin
        int c = (m_ptr + d) % NumInputs;
        if (!e_v && elig[c]) begin e_v = 1'b1; e_id = c; end
      end
    end
    if (e_v) e_vc = int'(req_vc_i[e_id]);
  endtask

  // Advance the model across one clock edge.
  task automatic model_commit();
    for (int v = 0; v < NumVC; v++) begin
      bit inc = credit_v_i && int'(credit_id_i) == v;
      bit dec = e_v && e_vc == v;
      if (inc && !dec) begin
        if (m_cnt[v] == VCDepth) m_err = 1'b1;
        else m_cnt[v]++;
      end else if (dec && !inc) begin
        m_cnt[v]--;
      end
    end
    if (e_v) begin
      if (!m_locked) begin
        m_ptr = (e_id + 1) % NumInputs;
        if (!req_last_i[e_id]) begin m_locked = 1'b1; m_lock_id = e_id; end
      end else if (req_last_i[e_id]) begin
        m_locked = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NumVC-1:0][CntWidth-1:0] ec;
    logic [NumInputs-1:0] eoh;
    for (int v = 0; v < NumVC; v++) ec[v] = CntWidth'(m_cnt[v]);
    eoh = e_v ? (NumInputs'(1) << e_id) : '0;
    check("gnt_v",      gnt_v_o, e_v);
    check("gnt_id",     gnt_id_o, e_v ? e_id : 0);
    check("gnt_vc",     gnt_vc_o, e_v ? e_vc : 0);
    check("gnt_oh",     gnt_oh_o, eoh);
    check("update_rr",  update_rr_arb_o, eoh);
    check("locked",     locked_o, m_locked);
    check("credit_cnt", credit_cnt_o, ec);
    check("credit_err", credit_err_o, m_err);
  endtask

  // One cycle: inputs were driven at the falling edge; check, then clock.
  task automatic step();
    model_eval();
    #1;
    check_outputs();
    @(posedge clk_i);
    model_commit();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    req_v_i = '0; req_vc_i = '0; req_last_i = '0;
    credit_v_i = 1'b0; credit_id_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    #1;
    model_reset();
    check("rst_locked", locked_o, 0);
    check("rst_cnt", credit_cnt_o, {NumVC{CntWidth'(VCDepth)}});
    check("rst_err", credit_err_o, 0);
    check("rst_gnt_v", gnt_v_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    @(negedge clk_i);
    do_reset();

    // Round robin on VC 0 until its credits run out.
    req_v_i = 5'b10110; req_last_i = '1;
    #1 check("rr_first", gnt_id_o, 1);
    step();
    check("rr_second", gnt_id_o, 2);
    step();
    check("rr_blocked", gnt_v_o, 0);
    check("rr_cnt0_empty", credit_cnt_o[0], 0);
    step();
    credit_v_i = 1'b1; credit_id_i = 2'd0;
    step();
    credit_v_i = 1'b0;
    step();
    step();

    // Three-flit packet from input 3 on VC 2 with input 0 competing.
    do_reset();
    req_v_i = 5'b01000; req_vc_i[3] = 2'd2; req_last_i = '0;
    #1 check("lk_head", gnt_id_o, 3);
    step();
    req_v_i = 5'b01001; req_vc_i[0] = 2'd0; req_last_i[0] = 1'b1;
    credit_v_i = 1'b1; credit_id_i = 2'd2;
    #1 check("lk_body", gnt_id_o, 3);
    check("lk_locked1", locked_o, 1);
    step();
    check("lk_cnt2_same", credit_cnt_o[2], 1);
    credit_v_i = 1'b0; req_last_i[3] = 1'b1;
    #1 check("lk_tail", gnt_id_o, 3);
    check("lk_locked2", locked_o, 1);
    step();
    req_v_i = 5'b00001;
    #1 check("lk_after", gnt_id_o, 0);
    check("lk_unlocked", locked_o, 0);
    step();

    // Credit return into an empty VC 1.
    do_reset();
    req_v_i = 5'b00100; req_vc_i[2] = 2'd1; req_last_i = '1;
    step(); step();
    credit_v_i = 1'b1; credit_id_i = 2'd1;
    #1;
`ifdef FLOO_SA_CREDIT_BYPASS_EN
    check("byp_gnt_now", gnt_v_o, 1);
    step();
    check("byp_cnt_zero", credit_cnt_o[1], 0);
`else
    check("nobyp_gnt_now", gnt_v_o, 0);
    step();
    credit_v_i = 1'b0;
    #1 check("nobyp_gnt_next", gnt_v_o, 1);
    step();
    check("nobyp_cnt_zero", credit_cnt_o[1], 0);
`endif
    credit_v_i = 1'b0;

    // Grant and credit on VC 3 in the same cycle.
    do_reset();
    req_v_i = 5'b00001; req_vc_i[0] = 2'd3; req_last_i = '1;
    step();
    credit_v_i = 1'b1; credit_id_i = 2'd3;
    step();
    check("same_vc3_cnt", credit_cnt_o[3], 1);

    // Credit overflow on a full VC 0 sets the sticky error.
    req_v_i = '0; credit_id_i = 2'd0;
    step();
    credit_v_i = 1'b0;
    check("ovf_err", credit_err_o, 1);
    check("ovf_cnt0", credit_cnt_o[0], 2);
    step(); step();
    check("ovf_err_sticky", credit_err_o, 1);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    req_v_i = 5'b01000; req_vc_i[3] = 2'd2; req_last_i = '0;
    step(); step();
    check("mid_locked", locked_o, 1);
    check("mid_cnt2", credit_cnt_o[2], 0);
    #2 rst_ni = 1'b0;
    #1;
    check("async_locked", locked_o, 0);
    check("async_cnt", credit_cnt_o, {NumVC{CntWidth'(VCDepth)}});
    check("async_gnt_v", gnt_v_o, 0);
    model_reset();
    @(negedge clk_i);
    do_reset();

    // Randomized packet traffic.
    for (int i = 0; i < NumInputs; i++) begin
      src_vc[i]   = $urandom_range(NumVC - 1);
      src_left[i] = $urandom_range(3, 1);
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < NumInputs; i++) begin
        req_v_i[i]    = ($urandom_range(99) < 70);
        req_vc_i[i]   = NumVCWidth'(src_vc[i]);
        req_last_i[i] = (src_left[i] == 1);
      end
      credit_v_i  = ($urandom_range(99) < 35);
      credit_id_i = NumVCWidth'($urandom_range(NumVC - 1));
      model_eval();
      if (e_v) begin
        src_left[e_id]--;
        if (src_left[e_id] == 0) begin
          src_vc[e_id]   = $urandom_range(NumVC - 1);
          src_left[e_id] = $urandom_range(3, 1);
        end
      end
      step();
      if (cyc % 200 == 199) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
